// File: rtl/fetch_byte_queue.sv
// Instruction byte queue between 8-byte fetch fills and a 15-byte decode window.
// Circular byte buffer with head/tail pointers and an occupancy counter.
module fetch_byte_queue #(
   parameter int          DEPTH_BYTES = 32,
   parameter logic [63:0] RESET_PC    = 64'h0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          redirect_valid,
   input  logic [63:0]                   redirect_pc,
   input  logic                          fill_valid,
   input  logic [63:0]                   fill_data,
   output logic                          fill_ready,
   output logic [63:0]                   fetch_pc,
   output logic [119:0]                  dc_bytes,
   output logic [63:0]                   dc_pc,
   output logic [$clog2(DEPTH_BYTES):0]  dc_count,
   output logic                          dc_valid,
   input  logic                          consume_valid,
   input  logic [3:0]                    consume_len,
   output logic                          consume_err
);

   localparam int PTR_W = $clog2(DEPTH_BYTES);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       mem_q [DEPTH_BYTES];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;
   logic [63:0]      dc_pc_q, fetch_pc_q;
   logic             err_q;

   logic             fill_acc, cons_req, cons_legal, cons_acc, cons_drop;
   logic [CNT_W-1:0] len_ext;
   logic [CNT_W-1:0] count_nxt;

   assign len_ext    = CNT_W'(consume_len);
   assign fill_ready = (CNT_W'(DEPTH_BYTES) - count_q) >= CNT_W'(8);
   assign fill_acc   = fill_valid && fill_ready && !redirect_valid;
   assign cons_req   = consume_valid && !redirect_valid;
   assign cons_legal = (consume_len != 4'd0) && (len_ext <= count_q);
   assign cons_acc   = cons_req && cons_legal;
   assign cons_drop  = cons_req && !cons_legal;

   always_comb begin
      count_nxt = count_q;
      if (fill_acc) count_nxt = count_nxt + CNT_W'(8);
      if (cons_acc) count_nxt = count_nxt - len_ext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         dc_pc_q    <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         err_q      <= 1'b0;
      end else if (redirect_valid) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         dc_pc_q    <= redirect_pc;
         fetch_pc_q <= redirect_pc;
      end else begin
         count_q <= count_nxt;
         if (fill_acc) begin
            tail_q     <= tail_q + PTR_W'(8);
            fetch_pc_q <= fetch_pc_q + 64'd8;
         end
         if (cons_acc) begin
            head_q  <= head_q + PTR_W'(consume_len);
            dc_pc_q <= dc_pc_q + 64'(consume_len);
         end
         if (cons_drop) err_q <= 1'b1;
      end
   end

   // Byte storage needs no reset: bytes beyond dc_count are masked on read.
   always_ff @(posedge clk) begin
      if (fill_acc && !reset) begin
         for (int k = 0; k < 8; k++)
            mem_q[tail_q + PTR_W'(k)] <= fill_data[8*k +: 8];
      end
   end

   always_comb begin
      dc_bytes = '0;
      for (int i = 0; i < 15; i++) begin
         if (CNT_W'(i) < count_q)
            dc_bytes[119-8*i -: 8] = mem_q[head_q + PTR_W'(i)];
      end
   end

   assign dc_count    = count_q;
   assign dc_valid    = count_q >= CNT_W'(15);
   assign dc_pc       = dc_pc_q;
   assign fetch_pc    = fetch_pc_q;
   assign consume_err = err_q;

endmodule
